// File: rtl/rs_issue_scheduler.sv
// Issue-select controller for the 5-entry reservation station: oldest-first grant,
// gated by functional-unit availability and a CDB writeback-slot reservation.
module rs_issue_scheduler #(
   parameter int RS_SZ    = 5,
   parameter int ALU_LAT  = 1,
   parameter int MEM_LAT  = 2,
   parameter int MULT_LAT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [RS_SZ-1:0] ready_vec,
   input  logic             alloc_en,
   input  logic [2:0]       alloc_idx,
   input  logic             stall,
   input  logic             flush,
   output logic             issue_en,
   output logic [2:0]       issue_idx,
   output logic [RS_SZ-1:0] issue_onehot,
   output logic             cdb_slot_valid,
   output logic [2:0]       cdb_slot_idx
);

   localparam int MAX_LAT = (ALU_LAT > MEM_LAT) ?
                            ((ALU_LAT > MULT_LAT) ? ALU_LAT : MULT_LAT) :
                            ((MEM_LAT > MULT_LAT) ? MEM_LAT : MULT_LAT);
   localparam int SW = $clog2(MAX_LAT + 1);
   localparam int CW = $clog2(MEM_LAT + 1);

   logic [MAX_LAT:0] slot_valid, slot_valid_nxt;
   logic [2:0]       slot_idx     [MAX_LAT+1];
   logic [2:0]       slot_idx_nxt [MAX_LAT+1];
   logic [CW-1:0]    mem_cnt;
   logic [RS_SZ-1:0] older [RS_SZ];
   logic [RS_SZ-1:0] elig, grant;
   logic             hold, mem_free, wb_en;
   logic [SW-1:0]    wb_pos;

   assign hold     = reset | flush | stall;
   assign mem_free = (mem_cnt == '0);

   // Slot[L] before the shift is the slot a grant of latency L would claim after it.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      elig = '0;
      if (!hold) begin
         elig[0] = ready_vec[0] & ~slot_valid[ALU_LAT];
         elig[1] = ready_vec[1] & mem_free & ~slot_valid[MEM_LAT];
         elig[2] = ready_vec[2] & mem_free;
         for (int i = 3; i < RS_SZ; i++)
            elig[i] = ready_vec[i] & ~slot_valid[MULT_LAT];
      end
   end

   always_comb begin
      grant = elig;
      for (int i = 0; i < RS_SZ; i++)
         for (int j = 0; j < RS_SZ; j++)
            if (j != i && elig[j] && older[j][i])
               grant[i] = 1'b0;
   end

   always_comb begin
      issue_en     = |grant;
      issue_onehot = grant;
      issue_idx    = '0;
      for (int i = 0; i < RS_SZ; i++)
         if (grant[i])
            issue_idx = 3'(i);
   end

   always_comb begin
      wb_en  = issue_en & ~grant[2];
      wb_pos = SW'(MULT_LAT - 1);
      if (grant[0])
         wb_pos = SW'(ALU_LAT - 1);
      else if (grant[1])
         wb_pos = SW'(MEM_LAT - 1);
   end

   always_comb begin
      slot_valid_nxt = {1'b0, slot_valid[MAX_LAT:1]};
      for (int d = 0; d < MAX_LAT; d++)
         slot_idx_nxt[d] = slot_idx[d+1];
      slot_idx_nxt[MAX_LAT] = '0;
      if (wb_en) begin
         slot_valid_nxt[wb_pos] = 1'b1;
         slot_idx_nxt[wb_pos]   = issue_idx;
      end
   end

   // mem_cnt holds the busy cycles left after the issue cycle, so the next
   // memory grant can land exactly MEM_LAT cycles after the previous one.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         slot_valid <= '0;
         // NOTE: the idx array is reset too, so cdb_slot_idx reads 0 when idle.
         for (int d = 0; d <= MAX_LAT; d++)
            slot_idx[d] <= '0;
         mem_cnt <= '0;
         for (int i = 0; i < RS_SZ; i++)
            for (int j = 0; j < RS_SZ; j++)
               older[i][j] <= (i < j);
      end else begin
         slot_valid <= slot_valid_nxt;
         slot_idx   <= slot_idx_nxt;
         if (grant[1] || grant[2])
            mem_cnt <= CW'(MEM_LAT - 1);
         else if (!mem_free)
            mem_cnt <= mem_cnt - 1'b1;
         if (alloc_en && int'(alloc_idx) < RS_SZ)
            for (int i = 0; i < RS_SZ; i++)
               for (int j = 0; j < RS_SZ; j++)
                  if (i == int'(alloc_idx))
                     older[i][j] <= 1'b0;
                  else if (j == int'(alloc_idx))
                     older[i][j] <= 1'b1;
      end
   end

   assign cdb_slot_valid = slot_valid[0];
   assign cdb_slot_idx   = slot_idx[0];

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: a cycle-level reference model built on an
// age-ordered list and a calendar of booked broadcast cycles.
module tb_rs_issue_scheduler;

   localparam int ALU_LAT  = 1;
   localparam int MEM_LAT  = 2;
   localparam int MULT_LAT = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] ready_vec = '0;
   logic       alloc_en = 1'b0;
   logic [2:0] alloc_idx = '0;
   logic       stall = 1'b0;
   logic       flush = 1'b0;
   logic       issue_en;
   logic [2:0] issue_idx;
   logic [4:0] issue_onehot;
   logic       cdb_slot_valid;
   logic [2:0] cdb_slot_idx;

   rs_issue_scheduler dut (
      .clock(clock), .reset(reset), .ready_vec(ready_vec), .alloc_en(alloc_en),
      .alloc_idx(alloc_idx), .stall(stall), .flush(flush), .issue_en(issue_en),
      .issue_idx(issue_idx), .issue_onehot(issue_onehot),
      .cdb_slot_valid(cdb_slot_valid), .cdb_slot_idx(cdb_slot_idx)
   );

   always #5 clock = ~clock;

   typedef struct { bit en; int idx; } iss_t;
   typedef struct { int cyc; int idx; } cdb_t;

   iss_t issue_q[$];
   cdb_t cdb_q[$];     // expected broadcasts, sorted by cycle
   int   age_q[$];     // oldest entry first
   int   mem_free_at;
   int   cyc;
   bit   mon_on;
   int   checks;
   int   errors;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit is_booked(input int c);
      foreach (cdb_q[k])
         if (cdb_q[k].cyc == c)
            return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit eligible(input int i);
      case (i)
         0:       return !is_booked(cyc + ALU_LAT);
         1:       return cyc >= mem_free_at && !is_booked(cyc + MEM_LAT);
         2:       return cyc >= mem_free_at;
         default: return !is_booked(cyc + MULT_LAT);
      endcase
   endfunction

   task automatic book(input int c, input int idx);
      int   pos;
      cdb_t item;
      pos  = cdb_q.size();
      item = '{cyc: c, idx: idx};
      for (int k = 0; k < cdb_q.size(); k++)
         if (cdb_q[k].cyc > c) begin
            pos = k;
            break;
         end
      cdb_q.insert(pos, item);
   endtask

   task automatic model(input logic [4:0] rv, input logic ae, input int ai,
                        input logic st, input logic fl, input logic rs);
      int   win;
      int   lat;
      int   pos;
      iss_t e;
      win = -1;
      if (!(rs || fl || st))
         foreach (age_q[p])
            if (win < 0 && rv[age_q[p]] && eligible(age_q[p]))
               win = age_q[p];
      e.en  = (win >= 0);
      e.idx = (win >= 0) ? win : 0;
      issue_q.push_back(e);
      if (win >= 0) begin
         lat = (win == 0) ? ALU_LAT : (win <= 2) ? MEM_LAT : MULT_LAT;
         if (win != 2)
            book(cyc + lat, win);
         if (win == 1 || win == 2)
            mem_free_at = cyc + MEM_LAT;
      end
      if (rs || fl) begin
         while (cdb_q.size() > 0 && cdb_q[$].cyc > cyc)
            void'(cdb_q.pop_back());
         mem_free_at = 0;
         age_q = '{0, 1, 2, 3, 4};
      end else if (ae) begin
         pos = -1;
         foreach (age_q[p])
            if (age_q[p] == ai)
               pos = p;
         if (pos >= 0)
            age_q.delete(pos);
         age_q.push_back(ai);
      end
   endtask

   task automatic drive(input logic [4:0] rv, input logic ae, input int ai,
                        input logic st, input logic fl, input logic rs);
      @(posedge clock);
      #1;
      cyc++;
      ready_vec = rv;
      alloc_en  = ae;
      alloc_idx = 3'(ai);
      stall     = st;
      flush     = fl;
      reset     = rs;
      model(rv, ae, ai, st, fl, rs);
      mon_on = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         drive(5'b00000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      drive(5'b00000, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      drive(5'b00000, 1'b0, 0, 1'b0, 1'b0, 1'b1);
   endtask

   always @(negedge clock) begin
      if (mon_on) begin
         if (issue_q.size() == 0) begin
            errors++;
            $display("FAIL issue_q empty at cycle %0d", cyc);
         end else begin
            iss_t e;
            e = issue_q.pop_front();
            check("issue_en", 32'(issue_en), 32'(e.en));
            check("issue_idx", 32'(issue_idx), 32'(e.idx));
            check("issue_onehot", 32'(issue_onehot), e.en ? (32'd1 << e.idx) : 32'd0);
         end
         if (cdb_q.size() > 0 && cdb_q[0].cyc == cyc) begin
            check("cdb_valid", 32'(cdb_slot_valid), 32'd1);
            check("cdb_idx", 32'(cdb_slot_idx), 32'(cdb_q[0].idx));
            void'(cdb_q.pop_front());
         end else begin
            check("cdb_valid", 32'(cdb_slot_valid), 32'd0);
         end
      end
   end

   initial begin
      cyc = 0; checks = 0; errors = 0; mon_on = 1'b0; mem_free_at = 0;
      age_q = '{0, 1, 2, 3, 4};

      // Basic ALU issue and one-cycle broadcast.
      do_reset();
      drive(5'b00001, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      idle(4);

      // Age order: 4 then 0 allocated, so 4 is older.
      do_reset();
      drive(5'b00000, 1'b1, 4, 1'b0, 1'b0, 1'b0);
      drive(5'b00000, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      drive(5'b10001, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      drive(5'b00001, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      idle(4);

      // Memory port: load then store contending.
      do_reset();
      drive(5'b00010, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      repeat (3) drive(5'b00100, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      idle(4);

      // CDB conflict: multiply holds the slot the ALU wants at t3.
      do_reset();
      drive(5'b01000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      idle(2);
      repeat (2) drive(5'b00001, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      idle(6);

      // Stall suppresses the grant for three cycles.
      do_reset();
      repeat (3) drive(5'b00001, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      drive(5'b00001, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Flush mid-flight cancels the multiply broadcast and restores index order.
      do_reset();
      drive(5'b00000, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      drive(5'b01000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      idle(1);
      drive(5'b00000, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      drive(5'b10001, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      drive(5'b00110, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      idle(6);

      // Randomized traffic.
      do_reset();
      for (int n = 0; n < 3000; n++)
         drive(5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0),
               $urandom_range(0, 4), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) == 0));
      idle(8);

      @(negedge clock);
      #1;
      check("cdb_drain", 32'(cdb_q.size()), 32'd0);
      check("issue_drain", 32'(issue_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
